mu0_mem_arbiter: RTL
====================

Name: mu0_mem_arbiter

Overview:
Parametrised memory front-end for the mu0 system. It replaces the single hard-wired override path with NUM_CH requester channels, each using a valid/ready request and a one-cycle response pulse. It arbitrates between channels, drives the shared memory's memRq/readNotWrite/addr/dataIn for a fixed MEM_LAT cycles, and returns read data to the winning channel. Channel 0 is the debug/loader port; the higher channels serve the CPU fetch/data paths.

Parameters:
DATA_W, 16, memory word width
ADDR_W, 16, memory address width
NUM_CH, 2, number of requester channels (>=1)
MEM_LAT, 1, cycles mem_rq is held before mem_rdata is sampled (>=1)
RR_MODE, 0, 0 = fixed priority (lowest index wins), 1 = round-robin

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous reset, active-high
req_valid  in  NUM_CH  per-channel request valid
req_ready  out  NUM_CH  per-channel accept, one-hot or zero
req_rnw  in  NUM_CH  per-channel 1=read, 0=write
req_addr  in  NUM_CH*ADDR_W  channel i at [i*ADDR_W +: ADDR_W]
req_wdata  in  NUM_CH*DATA_W  channel i at [i*DATA_W +: DATA_W]
rsp_valid  out  NUM_CH  one-cycle completion pulse for the channel
rsp_rdata  out  DATA_W  read data, valid only while any rsp_valid bit is 1
busy  out  1  high in ACCESS and RESP
mem_rq  out  1  memory request to the memory block
mem_rnw  out  1  memory readNotWrite
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data

Behaviour:
- Reset is asynchronous and active-high on rst, with clock clk.
- Reset values: state IDLE; mem_rq, mem_rnw, mem_addr, mem_wdata, rsp_valid, rsp_rdata, busy all 0; latched grant 0; RR pointer NUM_CH-1, so channel 0 is searched first.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - Combinational arbitration over req_valid.
  - req_ready[w]=1 for the winner only, and only in IDLE.
  - Transfer happens on the edge where req_valid[w]&req_ready[w]; the edge latches w, rnw, addr and wdata.
  - Next state ACCESS; latency counter loads MEM_LAT-1.
  - With no valid bit set, stay in IDLE with all outputs 0.
- ACCESS:
  - mem_rq=1 and mem_rnw/mem_addr/mem_wdata show the latched request, held stable for exactly MEM_LAT cycles.
  - When the counter reaches 0: if the request is a read, capture mem_rdata into rsp_rdata on that edge; go to RESP.
- RESP:
  - mem_rq=0; rsp_valid[w]=1 for exactly one cycle.
  - Writes also pulse rsp_valid, with rsp_rdata=0.
  - Next state IDLE.
- Latency: acceptance edge T → mem_rq high in cycles T+1..T+MEM_LAT → rsp_valid in cycle T+MEM_LAT+1. Peak throughput is one access per MEM_LAT+2 cycles.
- Arbitration:
  - RR_MODE=0: lowest asserted index wins.
  - RR_MODE=1: search starts at pointer+1, modulo NUM_CH; the pointer updates to w on acceptance only.
- req_ready is always 0 outside IDLE. Requests arriving during ACCESS/RESP wait; a requester may drop valid before ready without effect.
- Request inputs are ignored after acceptance; changing them mid-access does not affect the memory bus.
- Reset mid-operation aborts the access: mem_rq drops immediately, no rsp_valid is issued, and the pointer is restored.
- NUM_CH=1: arbitration degenerates to req_ready=IDLE.
- Address/data pass through unmodified; no wrap or width arithmetic beyond the latency counter, which is sized to clog2(MEM_LAT)+1.

Decomposition:
- Package mu0_mem_pkg: state enum (IDLE/ACCESS/RESP), default DATA_W/ADDR_W constants, a helper function for channel slice offsets.
- Sub-module mu0_rr_arbiter (NUM_CH, RR_MODE): purely combinational one-hot grant from the req vector and pointer.
- FSM, latches and counter stay in the top level.

Test Plan:
- Reset then a ch0 read to addr 0x0010 (memory holds 0x1234), MEM_LAT=1 → req_ready[0] on cycle 0; mem_rq on cycle 1 only, with mem_addr=0x0010 and mem_rnw=1; rsp_valid=2'b01 on cycle 2 with rsp_rdata=0x1234.
- ch1 writes 0xBEEF to 0x0020 with MEM_LAT=3 → mem_rq high for 3 cycles, mem_wdata=0xBEEF stable throughout; rsp_valid=2'b10 on cycle 4 with rsp_rdata=0; a readback from 0x0020 returns 0xBEEF.
- Both channels valid continuously, RR_MODE=0 → ch0 wins every arbitration and ch1 starves. RR_MODE=1 → grants alternate 0,1,0,1, with ready only in IDLE cycles spaced MEM_LAT+2 apart.
- ch1 requests during a ch0 ACCESS → req_ready[1] stays 0 until the cycle after ch0's RESP, then ch1 is granted.
- rst asserted in the second ACCESS cycle with MEM_LAT=3 → mem_rq goes 0 asynchronously, no rsp_valid, busy=0; after release the next grant goes to ch0 first.
- A requester changes req_addr from 0x0030 to 0x0040 during its ACCESS → mem_addr stays 0x0030 and the read returns the content of 0x0030.

Source files
------------

// File: rtl/mu0_mem_pkg.sv
// Shared types and constants for the mu0 memory arbiter.
// Holds the FSM state encoding and the packed-channel slice helper.
package mu0_mem_pkg;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  // Base bit offset of channel ch inside a packed per-channel bus of width w.
  function automatic int ch_off(input int ch, input int w);
    return ch * w;
  endfunction
endpackage

// File: rtl/mu0_mem_arbiter_if.sv
// Requester-side and memory-side bus of the mu0 memory arbiter.
// slave is the arbiter's view; master is the requesters/memory view.
interface mu0_mem_arbiter_if
  import mu0_mem_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);
  logic [NUM_CH-1:0]        req_valid;
  logic [NUM_CH-1:0]        req_ready;
  logic [NUM_CH-1:0]        req_rnw;
  logic [NUM_CH*ADDR_W-1:0] req_addr;
  logic [NUM_CH*DATA_W-1:0] req_wdata;
  logic [NUM_CH-1:0]        rsp_valid;
  logic [DATA_W-1:0]        rsp_rdata;
  logic                     busy;
  logic                     mem_rq;
  logic                     mem_rnw;
  logic [ADDR_W-1:0]        mem_addr;
  logic [DATA_W-1:0]        mem_wdata;
  logic [DATA_W-1:0]        mem_rdata;

  modport slave (
    input  req_valid, req_rnw, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, busy,
           mem_rq, mem_rnw, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_rnw, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, busy,
           mem_rq, mem_rnw, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mu0_rr_arbiter.sv
// Combinational one-hot grant over a request vector.
// RR_MODE=0: lowest index wins; RR_MODE=1: search starts just after i_ptr.
module mu0_rr_arbiter
  import mu0_mem_pkg::*;
#(
  parameter int NUM_CH  = 2,
  parameter int RR_MODE = 0,
  localparam int PW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic [NUM_CH-1:0] i_req,
  input  logic [PW-1:0]     i_ptr,
  output logic [NUM_CH-1:0] o_gnt,
  output logic [PW-1:0]     o_idx
);
  logic w_found;
  int   w_c;

  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_c     = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      w_c = (RR_MODE != 0) ? ((int'(i_ptr) + 1 + k) % NUM_CH) : k;
      if (!w_found && i_req[w_c]) begin
        w_found    = 1'b1;
        o_gnt[w_c] = 1'b1;
        o_idx      = PW'(w_c);
      end
    end
  end
endmodule

// File: rtl/mu0_mem_arbiter.sv
// Multi-channel front-end for the mu0 shared memory: arbitrates, holds the
// memory request for MEM_LAT cycles, then pulses a response to the winner.
module mu0_mem_arbiter
  import mu0_mem_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int NUM_CH  = 2,
  parameter int MEM_LAT = 1,
  parameter int RR_MODE = 0
) (
  input logic              i_clk,
  input logic              i_rst,
  mu0_mem_arbiter_if.slave bus
);
  localparam int PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CW = $clog2(MEM_LAT) + 1;

  state_e            r_state, w_state_nxt;
  logic [PW-1:0]     r_ptr;
  logic [PW-1:0]     r_gnt;
  logic              r_rnw;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic [CW-1:0]     r_cnt;

  logic [NUM_CH-1:0] w_gnt;
  logic [PW-1:0]     w_idx;
  logic              w_accept;

  mu0_rr_arbiter #(
    .NUM_CH  (NUM_CH),
    .RR_MODE (RR_MODE)
  ) u_arb (
    .i_req (bus.req_valid),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_ptr   <= PW'(NUM_CH - 1);
      r_gnt   <= '0;
      r_rnw   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_gnt   <= w_idx;
        r_rnw   <= bus.req_rnw[w_idx];
        r_addr  <= bus.req_addr[ch_off(int'(w_idx), ADDR_W) +: ADDR_W];
        r_wdata <= bus.req_wdata[ch_off(int'(w_idx), DATA_W) +: DATA_W];
        r_rdata <= '0;
        r_cnt   <= CW'(MEM_LAT - 1);
        if (RR_MODE != 0) r_ptr <= w_idx;
      end else if (r_state == ACCESS) begin
        // Last access cycle: the memory word is valid on this edge.
        if (r_cnt == '0) r_rdata <= r_rnw ? bus.mem_rdata : '0;
        else             r_cnt   <= r_cnt - CW'(1);
      end
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_accept      = 1'b0;
    bus.req_ready = '0;
    bus.rsp_valid = '0;
    bus.rsp_rdata = '0;
    bus.busy      = 1'b0;
    bus.mem_rq    = 1'b0;
    bus.mem_rnw   = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    unique case (r_state)
      IDLE: begin
        bus.req_ready = w_gnt;
        if (|w_gnt) begin
          w_accept    = 1'b1;
          w_state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        bus.busy      = 1'b1;
        bus.mem_rq    = 1'b1;
        bus.mem_rnw   = r_rnw;
        bus.mem_addr  = r_addr;
        bus.mem_wdata = r_wdata;
        if (r_cnt == '0) w_state_nxt = RESP;
      end
      RESP: begin
        bus.busy             = 1'b1;
        bus.rsp_valid[r_gnt] = 1'b1;
        bus.rsp_rdata        = r_rdata;
        w_state_nxt          = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end
endmodule
